// File: rtl/tap_upload_if.sv
// -----------------------------------------------------------------------------
// tap_upload_if -- HPS ioctl upload port and memory read port for tap_upload
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface tap_upload_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic [24:0] file_size;
  logic        busy;
  logic        err;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, start_addr, end_addr,
           mem_data, mem_ack,
    output ioctl_din, ioctl_wait, mem_addr, mem_rd, file_size, busy, err
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, start_addr, end_addr,
           mem_data, mem_ack,
    input  ioctl_din, ioctl_wait, mem_addr, mem_rd, file_size, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/tap_upload.sv
// -----------------------------------------------------------------------------
// tap_upload -- streams a memory range to the HPS as a KC TAP file
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tap_upload (
  input  wire logic   clk,
  input  wire logic   reset_n,
  tap_upload_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_BLKNUM = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_FETCH  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        upload_q, upload_d;
  logic [15:0] last_q, last_d;
  logic [9:0]  nblk_q, nblk_d;
  logic [9:0]  blk_q, blk_d;
  logic [6:0]  r_q, r_d;
  logic [16:0] cur_q, cur_d;
  logic [24:0] pos_q, pos_d;
  logic [24:0] fsize_q, fsize_d;
  logic [7:0]  din_q, din_d;
  logic [15:0] maddr_q, maddr_d;
  logic        mrd_q, mrd_d;
  logic        err_q, err_d;

  logic        start_evt, rd_ok, rd_bad, last_blk, in_range, blk_end;
  logic [16:0] span_len;
  logic [9:0]  nblk_new;
  logic [24:0] fsize_new;

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_byte = 8'hC3;
      4'd1:    hdr_byte = 8'h4B;
      4'd2:    hdr_byte = 8'h43;
      4'd3:    hdr_byte = 8'h2D;
      4'd4:    hdr_byte = 8'h54;
      4'd5:    hdr_byte = 8'h41;
      4'd6:    hdr_byte = 8'h50;
      4'd7:    hdr_byte = 8'h45;
      4'd9:    hdr_byte = 8'h62;
      4'd10:   hdr_byte = 8'h79;
      4'd12:   hdr_byte = 8'h41;
      4'd13:   hdr_byte = 8'h46;
      4'd14:   hdr_byte = 8'h2E;
      default: hdr_byte = 8'h20;
    endcase
  endfunction

  always_comb begin
    start_evt = bus.ioctl_upload & ~upload_q;
    rd_ok     = bus.ioctl_rd & (bus.ioctl_addr == pos_q);
    rd_bad    = bus.ioctl_rd & (bus.ioctl_addr != pos_q);
    last_blk  = (blk_q == nblk_q - 10'd1);
    in_range  = (cur_q <= {1'b0, last_q});
    blk_end   = (r_q == 7'd127);
    span_len  = (bus.end_addr >= bus.start_addr)
              ? ({1'b0, bus.end_addr} - {1'b0, bus.start_addr} + 17'd1) : 17'd0;
    // ceil(len/128) without an adder carry out of 17 bits
    nblk_new  = span_len[16:7] + {9'd0, |span_len[6:0]};
    fsize_new = 25'd16 + {8'd0, nblk_new, 7'd0} + {15'd0, nblk_new};
  end

  // Reset leaves upload_q high so an upload held across reset is not a new edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      upload_q <= 1'b1;
      last_q   <= 16'd0;
      nblk_q   <= 10'd0;
      blk_q    <= 10'd0;
      r_q      <= 7'd0;
      cur_q    <= 17'd0;
      pos_q    <= 25'd0;
      fsize_q  <= 25'd0;
      din_q    <= 8'd0;
      maddr_q  <= 16'd0;
      mrd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      upload_q <= upload_d;
      last_q   <= last_d;
      nblk_q   <= nblk_d;
      blk_q    <= blk_d;
      r_q      <= r_d;
      cur_q    <= cur_d;
      pos_q    <= pos_d;
      fsize_q  <= fsize_d;
      din_q    <= din_d;
      maddr_q  <= maddr_d;
      mrd_q    <= mrd_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.ioctl_upload) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start_evt) state_d = S_HDR;
        S_HDR:    if (rd_ok && pos_q[3:0] == 4'hF)
                    state_d = (nblk_q == 10'd0) ? S_DONE : S_BLKNUM;
        S_BLKNUM: if (rd_ok) state_d = S_DATA;
        S_DATA:   if (rd_ok) begin
                    if (in_range)    state_d = S_FETCH;
                    else if (blk_end) state_d = last_blk ? S_DONE : S_BLKNUM;
                  end
        S_FETCH:  if (bus.mem_ack) begin
                    if (blk_end) state_d = last_blk ? S_DONE : S_BLKNUM;
                    else         state_d = S_DATA;
                  end
        S_DONE:   state_d = S_DONE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    upload_d = bus.ioctl_upload;
    last_d   = last_q;
    nblk_d   = nblk_q;
    blk_d    = blk_q;
    r_d      = r_q;
    cur_d    = cur_q;
    pos_d    = pos_q;
    fsize_d  = fsize_q;
    din_d    = din_q;
    maddr_d  = maddr_q;
    mrd_d    = 1'b0;
    err_d    = err_q;
    if (bus.ioctl_upload) begin
      case (state_q)
        S_IDLE: begin
          if (start_evt) begin
            last_d  = bus.end_addr;
            nblk_d  = nblk_new;
            fsize_d = fsize_new;
            blk_d   = 10'd0;
            r_d     = 7'd0;
            cur_d   = {1'b0, bus.start_addr};
            pos_d   = 25'd0;
            din_d   = 8'd0;
            err_d   = 1'b0;
          end
        end
        S_HDR, S_BLKNUM, S_DATA, S_DONE: begin
          if (rd_bad) begin
            err_d = 1'b1;
            din_d = 8'd0;
          end else if (rd_ok) begin
            pos_d = pos_q + 25'd1;
            case (state_q)
              S_HDR:    din_d = hdr_byte(pos_q[3:0]);
              S_BLKNUM: begin
                din_d = last_blk ? 8'hFF : (blk_q[7:0] + 8'd1);
                r_d   = 7'd0;
              end
              S_DATA: begin
                cur_d = cur_q + 17'd1;
                if (in_range) begin
                  maddr_d = cur_q[15:0];
                  mrd_d   = 1'b1;
                end else begin
                  din_d = 8'd0;
                  r_d   = r_q + 7'd1;
                  if (blk_end) blk_d = blk_q + 10'd1;
                end
              end
              default:  din_d = 8'd0;
            endcase
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            din_d = bus.mem_data;
            r_d   = r_q + 7'd1;
            if (blk_end) blk_d = blk_q + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = bus.ioctl_rd | (state_q == S_FETCH);
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_rd     = mrd_q;
  assign bus.file_size  = fsize_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tap_upload.sv
// -----------------------------------------------------------------------------
// tb_tap_upload -- scoreboard bench for tap_upload
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_tap_upload;
  logic clk;
  logic reset_n;

  tap_upload_if bus ();

  tap_upload dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] val;
    bit         chk;
  } sb_t;

  sb_t sb_q[$];
  int  n_total = 0;
  int  n_bad   = 0;
  int  ack_delay = 1;
  int  mem_rd_cnt = 0;
  int  exp_maddr = 0;
  int  last_wait_len = 0;
  int  cur_s = 0;
  int  cur_e = 0;

  logic [7:0] hdr [16] = '{8'hC3, 8'h4B, 8'h43, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                           8'h20, 8'h62, 8'h79, 8'h20, 8'h41, 8'h46, 8'h2E, 8'h20};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_val(input int a);
    logic [15:0] v;
    v = a[15:0];
    return ((v[7:0] ^ v[15:8]) + 8'h11) | 8'h80;
  endfunction

  function automatic logic [7:0] ref_byte(input int off, input int s, input int e);
    int n, b, k, a;
    n = (e >= s) ? (e - s + 128) / 128 : 0;
    if (off < 16) return hdr[off];
    if (off >= 16 + 129 * n) return 8'h00;
    b = (off - 16) / 129;
    k = (off - 16) % 129;
    if (k == 0) return (b == n - 1) ? 8'hFF : 8'((b + 1) % 256);
    a = s + 128 * b + k - 1;
    return (a <= e) ? mem_val(a) : 8'h00;
  endfunction

  // Memory model: acks ack_delay cycles after the mem_rd cycle.
  initial begin
    logic [15:0] a;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'hEE;
    forever begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1) begin
        a = bus.mem_addr;
        mem_rd_cnt++;
        chk("mem_addr_seq", {16'd0, a}, {16'd0, exp_maddr[15:0]});
        exp_maddr++;
        repeat (ack_delay) @(posedge clk);
        #1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = mem_val(int'(a));
        @(posedge clk);
        #1;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'hEE;
      end
    end
  end

  // Monitor: a falling ioctl_wait marks ioctl_din as valid.
  initial begin
    logic wait_prev;
    int   wait_len;
    sb_t  e;
    wait_prev = 1'b0;
    wait_len  = 0;
    forever begin
      @(negedge clk);
      if (bus.ioctl_wait === 1'b1) begin
        wait_len++;
      end else begin
        if (wait_prev) begin
          last_wait_len = wait_len;
          if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_empty: got byte %0h want no response", bus.ioctl_din);
          end else begin
            e = sb_q.pop_front();
            if (e.chk) chk("ioctl_din", {24'd0, bus.ioctl_din}, {24'd0, e.val});
          end
        end
        wait_len = 0;
      end
      wait_prev = (bus.ioctl_wait === 1'b1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_read(input int off, input logic [7:0] exp, input bit chk_en);
    int guard;
    sb_q.push_back('{val: exp, chk: chk_en});
    @(posedge clk); #1;
    bus.ioctl_rd   = 1'b1;
    bus.ioctl_addr = 25'(off);
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b0;
    guard = 0;
    while (bus.ioctl_wait === 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_total++;
      n_bad++;
      $display("FAIL read_timeout off=%0d: got wait 1 want 0", off);
    end
    @(negedge clk); #1;
  endtask

  task automatic read_span(input int a, input int b);
    for (int o = a; o <= b; o++) do_read(o, ref_byte(o, cur_s, cur_e), 1'b1);
  endtask

  task automatic start_session(input logic [15:0] s, input logic [15:0] e, input int exp_fs);
    @(posedge clk); #1;
    bus.ioctl_upload = 1'b0;
    bus.start_addr   = s;
    bus.end_addr     = e;
    @(posedge clk); #1;
    bus.ioctl_upload = 1'b1;
    exp_maddr  = int'(s);
    mem_rd_cnt = 0;
    cur_s      = int'(s);
    cur_e      = int'(e);
    @(posedge clk); #1;
    chk("file_size", {7'd0, bus.file_size}, 32'(exp_fs));
    chk("busy_start", {31'd0, bus.busy}, 32'd1);
    chk("err_start", {31'd0, bus.err}, 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_din", {24'd0, bus.ioctl_din}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_file_size", {7'd0, bus.file_size}, 32'd0);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = 25'd0;
    bus.start_addr   = 16'd0;
    bus.end_addr     = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset_n = 1'b1;

    // Single block: header, block byte, wait timing, DONE bytes.
    start_session(16'h0300, 16'h037F, 145);
    do_read(0, 8'hC3, 1'b1);
    chk("wait_len_hdr", 32'(last_wait_len), 32'd1);
    read_span(1, 16);
    ack_delay = 5;
    do_read(17, mem_val(16'h0300), 1'b1);
    chk("wait_len_slow", 32'(last_wait_len), 32'd7);
    ack_delay = 1;
    do_read(18, mem_val(16'h0301), 1'b1);
    chk("wait_len_mem", 32'(last_wait_len), 32'd3);
    read_span(19, 144);
    chk("mem_rd_cnt_1blk", 32'(mem_rd_cnt), 32'd128);
    chk("mem_addr_last", {16'd0, bus.mem_addr}, 32'h037F);
    do_read(145, 8'h00, 1'b1);
    do_read(146, 8'h00, 1'b1);
    chk("mem_rd_cnt_past", 32'(mem_rd_cnt), 32'd128);

    // Three blocks with padding in the last one.
    start_session(16'h1000, 16'h1100, 403);
    read_span(0, 15);
    do_read(16, 8'h01, 1'b1);
    read_span(17, 144);
    do_read(145, 8'h02, 1'b1);
    read_span(146, 273);
    do_read(274, 8'hFF, 1'b1);
    do_read(275, mem_val(16'h1100), 1'b1);
    read_span(276, 402);
    chk("mem_rd_cnt_3blk", 32'(mem_rd_cnt), 32'd257);

    // Upload drops while a fetch is outstanding.
    start_session(16'h0300, 16'h037F, 145);
    read_span(0, 16);
    ack_delay = 10;
    sb_q.push_back('{val: 8'h00, chk: 1'b0});
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd17;
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.ioctl_upload = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_wait", {31'd0, bus.ioctl_wait}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_ack_ignored", {24'd0, bus.ioctl_din}, 32'hFF);
    chk("abort_busy_late", {31'd0, bus.busy}, 32'd0);
    ack_delay = 1;

    // Out-of-order read.
    start_session(16'h0300, 16'h037F, 145);
    read_span(0, 17);
    do_read(20, 8'h00, 1'b1);
    chk("err_set", {31'd0, bus.err}, 32'd1);
    do_read(18, mem_val(16'h0301), 1'b1);
    chk("err_sticky", {31'd0, bus.err}, 32'd1);

    // Reset in the middle of a fetch, upload held high throughout.
    start_session(16'h1000, 16'h1100, 403);
    read_span(0, 20);
    ack_delay = 8;
    sb_q.push_back('{val: 8'h00, chk: 1'b0});
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd21;
    @(posedge clk); #1;
    bus.ioctl_rd = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs();
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_restart", {31'd0, bus.busy}, 32'd0);
    chk("rst_ack_ignored", {24'd0, bus.ioctl_din}, 32'd0);
    ack_delay = 1;

    // Empty range: header only.
    start_session(16'h2000, 16'h1FFF, 16);
    read_span(0, 17);
    chk("mem_rd_cnt_empty", 32'(mem_rd_cnt), 32'd0);

    // Range ending at the top of memory.
    start_session(16'hFF80, 16'hFFFF, 145);
    read_span(0, 145);
    chk("mem_rd_cnt_top", 32'(mem_rd_cnt), 32'd128);
    chk("mem_addr_top", {16'd0, bus.mem_addr}, 32'hFFFF);

    @(posedge clk); #1;
    bus.ioctl_upload = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tap_upload.md
TAP_UPLOAD -- requirements
Module: tap_upload

Interface
REQ-001 The module SHALL have the ports listed in REQ-002 to REQ-015, with widths as given.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 reset_n  in  1  reset, synchronous, active-low.
REQ-004 ioctl_upload  in  1  HPS upload session active.
REQ-005 ioctl_rd  in  1  HPS byte-read strobe, one-cycle pulse.
REQ-006 ioctl_addr  in  25  file byte offset of the current read.
REQ-007 ioctl_din  out  8  byte returned to HPS.
REQ-008 ioctl_wait  out  1  stall to HPS; HPS issues no new ioctl_rd while high.
REQ-009 start_addr  in  16  first memory byte; sampled on ioctl_upload rising edge.
REQ-010 end_addr  in  16  last memory byte, inclusive; sampled with start_addr.
REQ-011 mem_addr  out  16  memory read address.
REQ-012 mem_rd  out  1  memory read request, one-cycle pulse.
REQ-013 mem_data / mem_ack  in  8 / 1  read data, valid in the cycle mem_ack is high.
REQ-014 file_size  out  25  total TAP length in bytes, valid from one cycle after the session starts.
REQ-015 busy / err  out  1 / 1  session active / out-of-order address seen.

Function
REQ-016 The output file format SHALL be KC TAP.
- Bytes 0-15 form the header: C3,'K','C','-','T','A','P','E',' ','b','y',' ','A','F','.',' '.
- N blocks of 129 bytes follow, with N = ceil((end-start+1)/128).
REQ-017 Each block SHALL be 1 block-number byte followed by 128 data bytes.
- Block number: (b+1) mod 256 for block index b, except the last block, which SHALL be 0xFF.
REQ-018 Data byte r (0..127) of block b SHALL come from memory at start+128*b+r if that address is <= end; otherwise it SHALL be 0x00 padding with no memory read.
REQ-019 file_size SHALL be 16 + 129*N, computed with shift-add ((N<<7)+N); no multiplier.
REQ-020 If end_addr < start_addr: N = 0, file_size = 16, and only header bytes are served.
REQ-021 FSM states SHALL be IDLE, HDR, BLKNUM, DATA, FETCH, DONE.
- IDLE -> HDR on ioctl_upload rise.
- HDR -> BLKNUM after byte 15.
- BLKNUM -> DATA.
- DATA -> FETCH for each in-range data byte.
- FETCH -> DATA on mem_ack.
- DATA -> BLKNUM after r = 127 when blocks remain.
- DATA -> DONE after r = 127 of the last block.
- Any state -> IDLE on ioctl_upload low.
REQ-022 Reads SHALL be strictly sequential from offset 0.
- If ioctl_addr differs from the expected offset, err SHALL set (sticky until next session), ioctl_din SHALL be 0x00, and the internal position SHALL NOT advance.
REQ-023 Header, block-number, pad and DONE bytes SHALL be timed as follows:
- ioctl_wait high in the ioctl_rd cycle only (combinational OR of ioctl_rd and pending).
- ioctl_din valid from the next cycle.
REQ-024 Memory bytes SHALL be timed as follows:
- mem_rd pulses with mem_addr valid one cycle after ioctl_rd.
- ioctl_wait stays high from ioctl_rd through the mem_ack cycle.
- ioctl_din is registered from mem_data in the cycle after mem_ack, and ioctl_wait goes low in that same cycle.
REQ-025 Reads at offsets >= file_size SHALL return 0x00 with single-cycle wait.
REQ-026 The memory address counter SHALL be 17-bit internally, so end_addr = 0xFFFF does not wrap to 0.
REQ-027 If ioctl_upload falls during FETCH, the module SHALL:
- return to IDLE;
- drop a pending mem_ack;
- deassert ioctl_wait next cycle.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 On reset_n low at a clock edge, the outputs SHALL take these values:
- state = IDLE;
- ioctl_din, mem_addr = 0;
- ioctl_wait, mem_rd, busy, err = 0;
- file_size = 0.
REQ-030 Reset SHALL abort any session mid-operation; a mem_ack arriving after reset SHALL be ignored.
REQ-031 After reset, a new session SHALL start only on a fresh ioctl_upload rising edge.

Verification
REQ-032 The bench SHALL cover the header case: start=0x0300, end=0x037F, upload, read offsets 0-15 -> C3 4B 43 2D 54 41 50 45 20 62 79 20 41 46 2E 20, file_size = 145.
REQ-033 The bench SHALL cover the single block case: same range, offset 16 -> 0xFF; offsets 17-144 -> mem[0x0300..0x037F]; 128 mem_rd pulses with mem_addr incrementing.
REQ-034 The bench SHALL cover the multi-block and padding case: start=0x1000, end=0x1100 (257 bytes) -> N = 3, file_size = 403; block bytes 01, 02, FF; last block holds 1 memory byte then 127 bytes of 0x00 with no mem_rd.
REQ-035 The bench SHALL cover the wait handshake: mem_ack delayed 5 cycles -> ioctl_wait high 7 consecutive cycles, ioctl_din = mem_data when wait falls.
REQ-036 The bench SHALL cover abort and error:
- ioctl_upload drops during FETCH -> busy = 0 next cycle, later mem_ack ignored.
- Offset 20 read after offset 17 -> err = 1, ioctl_din = 0x00.
REQ-037 The bench SHALL cover reset and edge ranges:
- reset_n low mid-block -> all outputs at REQ-029 values.
- end < start -> file_size = 16.
- start = 0xFF80, end = 0xFFFF -> N = 1, no wrap to 0x0000.
